// File: rtl/axi_brom_ctrl_if.sv
// AXI4 slave bus (128-bit data, 16-bit address) between a master and the boot-ROM sequencer.
// Every channel transfers on a clock edge where its valid and ready are both high; valid never waits for ready.
interface axi_brom_ctrl_if #(
    parameter int ID_WIDTH = 4
);
    logic [ID_WIDTH-1:0] awid;
    logic [15:0]         awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awvalid;
    logic                awready;

    logic [127:0]        wdata;
    logic [15:0]         wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;

    logic [ID_WIDTH-1:0] bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    logic [ID_WIDTH-1:0] arid;
    logic [15:0]         araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arvalid;
    logic                arready;

    logic [ID_WIDTH-1:0] rid;
    logic [127:0]        rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        output wdata, wstrb, wlast, wvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        output rready,
        input  awready, wready, bid, bresp, bvalid,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        input  wdata, wstrb, wlast, wvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        input  rready,
        output awready, wready, bid, bresp, bvalid,
        output arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/axi_brom_ctrl.sv
// AXI4 slave front-end for the 64 KB boot BRAM: one burst at a time, round-robin
// read/write arbitration, line-granular addressing with a 1-cycle registered-address read.
module axi_brom_ctrl #(
    parameter int ID_WIDTH = 4
) (
    input  logic                clka,
    input  logic                rsta,
    axi_brom_ctrl_if.slave      s_axi,
    output logic [15:0]         addra,
    output logic                ena,
    output logic [15:0]         wea,
    output logic [127:0]        dina,
    input  logic [127:0]        douta,
    output logic [1:0]          dbg_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_DATA = 2'd1,
        WR_RESP = 2'd2,
        RD      = 2'd3
    } state_t;

    state_t              state;
    logic                prio;      // 0: read wins a tie, 1: write wins
    logic [ID_WIDTH-1:0] id_q;
    logic [11:0]         line_q;
    logic                fixed_q;
    logic [8:0]          left_q;    // beats still to move through the BRAM port
    logic                rvalid_q;
    logic                rlast_q;

    logic                grant_rd;
    logic                grant_wr;
    logic                wr_hs;
    logic                rd_issue;
    logic [11:0]         next_line;
    logic                unused_sig;

    assign grant_rd  = (state == IDLE) && !rsta && s_axi.arvalid && (!s_axi.awvalid || !prio);
    assign grant_wr  = (state == IDLE) && !rsta && s_axi.awvalid && (!s_axi.arvalid || prio);
    assign wr_hs     = (state == WR_DATA) && !rsta && s_axi.wvalid;
    // A read is only launched when the R slot is free or being drained this cycle,
    // so douta is never overwritten while a stalled beat is still on R.
    assign rd_issue  = (state == RD) && !rsta && (left_q != 9'd0) && (!rvalid_q || s_axi.rready);
    assign next_line = fixed_q ? line_q : line_q + 12'd1;

    assign s_axi.arready = grant_rd;
    assign s_axi.awready = grant_wr;
    assign s_axi.wready  = (state == WR_DATA) && !rsta;
    assign s_axi.bvalid  = (state == WR_RESP);
    assign s_axi.bresp   = 2'b00;
    assign s_axi.bid     = id_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rlast   = rlast_q;
    assign s_axi.rresp   = 2'b00;
    assign s_axi.rid     = id_q;
    assign s_axi.rdata   = douta;

    assign ena       = wr_hs || rd_issue;
    assign wea       = wr_hs ? s_axi.wstrb : 16'h0000;
    assign dina      = s_axi.wdata;
    assign addra     = ena ? {line_q, 4'h0} : 16'h0000;
    assign dbg_state = state;

    // Transfer size is fixed at one line and the beat count comes from len, not wlast.
    assign unused_sig = ^{s_axi.awsize, s_axi.arsize, s_axi.wlast,
                          s_axi.awaddr[3:0], s_axi.araddr[3:0]};

    always_ff @(posedge clka) begin
        if (rsta) begin
            state    <= IDLE;
            prio     <= 1'b0;
            id_q     <= '0;
            line_q   <= 12'h000;
            fixed_q  <= 1'b0;
            left_q   <= 9'd0;
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_rd) begin
                        id_q    <= s_axi.arid;
                        line_q  <= s_axi.araddr[15:4];
                        fixed_q <= (s_axi.arburst == 2'b00);
                        left_q  <= {1'b0, s_axi.arlen} + 9'd1;
                        state   <= RD;
                        if (s_axi.awvalid) prio <= 1'b1;
                    end else if (grant_wr) begin
                        id_q    <= s_axi.awid;
                        line_q  <= s_axi.awaddr[15:4];
                        fixed_q <= (s_axi.awburst == 2'b00);
                        left_q  <= {1'b0, s_axi.awlen} + 9'd1;
                        state   <= WR_DATA;
                        if (s_axi.arvalid) prio <= 1'b0;
                    end
                end
                WR_DATA: begin
                    if (wr_hs) begin
                        line_q <= next_line;
                        left_q <= left_q - 9'd1;
                        if (left_q == 9'd1) state <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (s_axi.bready) state <= IDLE;
                end
                RD: begin
                    if (rd_issue) begin
                        line_q   <= next_line;
                        left_q   <= left_q - 9'd1;
                        rvalid_q <= 1'b1;
                        rlast_q  <= (left_q == 9'd1);
                    end else if (s_axi.rready) begin
                        rvalid_q <= 1'b0;
                        rlast_q  <= 1'b0;
                    end
                    if (rvalid_q && s_axi.rready && rlast_q) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
